// File: rtl/moore_pkg.sv
// Shared definitions for the multi-digit BCD Moore display path: mode
// encodings, the BCD-to-segment table and the single-digit BCD step.
package moore_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_UP    = 2'b01,
      MODE_DOWN  = 2'b10,
      MODE_CLEAR = 2'b11
   } mode_e;

   typedef struct packed {
      logic [3:0] digit;
      logic       carry;
   } bcd_step_t;

   // Active-high {g,f,e,d,c,b,a} patterns for digits 0..9.
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] seg;
      seg = 7'h00;
      for (int i = 0; i < 10; i++) begin
         if (d == 4'(i)) seg = SEG_TABLE[i];
      end
      return seg;
   endfunction

   // One digit of a ripple BCD increment/decrement; cin=0 leaves the digit alone.
   function automatic bcd_step_t bcd_step(input logic [3:0] d, input logic down,
                                          input logic cin);
      bcd_step_t r;
      r.digit = d;
      r.carry = 1'b0;
      if (cin) begin
         if (!down) begin
            if (d >= 4'd9) begin
               r.digit = 4'd0;
               r.carry = 1'b1;
            end else begin
               r.digit = d + 4'd1;
            end
         end else begin
            if (d == 4'd0) begin
               r.digit = 4'd9;
               r.carry = 1'b1;
            end else begin
               r.digit = d - 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-COUNT counter producing a one-cycle enable on its last
// state; clr restarts the period and masks the enable.
module tick_gen #(
   parameter int COUNT = 4
) (
   input  logic clockFPGA,
   input  logic RES,
   input  logic clr,
   output logic tick
);

   localparam int            W    = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [W-1:0]  LAST = W'(COUNT - 1);

   logic [W-1:0] cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of process ordering.
   always_ff @(posedge clockFPGA or negedge RES) begin
      if (!RES) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/moore_scan_display.sv
// Multi-digit BCD up/down Moore counter with tick-enable timing and a
// registered, time-multiplexed 7-segment scanner, all on clockFPGA.
module moore_scan_display
   import moore_pkg::*;
#(
   parameter int DIGITS         = 2,
   parameter int DIV_COUNT      = 25000000,
   parameter int SCAN_COUNT     = 50000,
   parameter bit WRAP           = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clockFPGA,
   input  logic                  RES,
   input  logic [1:0]            w,
   output logic                  tick,
   output logic [4*DIGITS-1:0]   mooreOut,
   output logic                  at_limit,
   output logic [6:0]            segment_display,
   output logic [DIGITS-1:0]     digit_en
);

   localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [6:0]        SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_TABLE[0] : SEG_TABLE[0];
   localparam logic [DIGITS-1:0] EN_RESET  = ~DIGITS'(1);

   logic [1:0]          w_meta;
   mode_e               w_s;
   logic                clr;
   logic                scan_tick;
   logic [4*DIGITS-1:0] count, count_next;
   logic                all_nine, all_zero;
   logic                carry;
   bcd_step_t           step;
   logic [IDX_W-1:0]    scan_idx, scan_idx_next;
   logic [3:0]          nibble;
   logic [6:0]          seg_next;
   logic [DIGITS-1:0]   en_next;

   always_ff @(posedge clockFPGA or negedge RES) begin
      if (!RES) begin
         w_meta <= 2'b00;
         w_s    <= MODE_HOLD;
      end else begin
         w_meta <= w;
         w_s    <= mode_e'(w_meta);
      end
   end

   assign clr = (w_s == MODE_CLEAR);

   tick_gen #(.COUNT(DIV_COUNT)) u_div (
      .clockFPGA (clockFPGA),
      .RES       (RES),
      .clr       (clr),
      .tick      (tick)
   );

   tick_gen #(.COUNT(SCAN_COUNT)) u_scan (
      .clockFPGA (clockFPGA),
      .RES       (RES),
      .clr       (1'b0),
      .tick      (scan_tick)
   );

   always_comb begin
      all_nine = 1'b1;
      all_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (count[4*i +: 4] != 4'd9) all_nine = 1'b0;
         if (count[4*i +: 4] != 4'd0) all_zero = 1'b0;
      end
   end

   // NOTE: every combinational output gets a default before any branch, so
   // no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      count_next = count;
      carry      = 1'b1;
      step       = '0;
      case (w_s)
         MODE_CLEAR: count_next = '0;
         MODE_UP, MODE_DOWN: begin
            if (tick && (WRAP || !((w_s == MODE_UP) ? all_nine : all_zero))) begin
               for (int i = 0; i < DIGITS; i++) begin
                  step                 = bcd_step(count[4*i +: 4], w_s == MODE_DOWN, carry);
                  count_next[4*i +: 4] = step.digit;
                  carry                = step.carry;
               end
            end
         end
         default: count_next = count;
      endcase
   end

   assign at_limit = ((w_s == MODE_UP) && all_nine) || ((w_s == MODE_DOWN) && all_zero);
   assign mooreOut = count;

   always_comb begin
      scan_idx_next = scan_idx;
      if (scan_tick) begin
         scan_idx_next = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end
   end

   // Digit select and its pattern come from the same index in one cycle.
   always_comb begin
      nibble  = 4'd0;
      en_next = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx == IDX_W'(i)) begin
            nibble     = count[4*i +: 4];
            en_next[i] = 1'b0;
         end
      end
      seg_next = SEG_ACTIVE_LOW ? ~bcd_to_seg(nibble) : bcd_to_seg(nibble);
   end

   always_ff @(posedge clockFPGA or negedge RES) begin
      if (!RES) begin
         count           <= '0;
         scan_idx        <= '0;
         digit_en        <= EN_RESET;
         segment_display <= SEG_RESET;
      end else begin
         count           <= count_next;
         scan_idx        <= scan_idx_next;
         digit_en        <= en_next;
         segment_display <= seg_next;
      end
   end

endmodule
